// File: rtl/fake6525_if.sv
// fake6525_if: host register-bus control signals (chip select, direction, register select).
interface fake6525_if;
    logic       _cs;
    logic       _write;
    logic [2:0] rs;

    modport master (output _cs, output _write, output rs);
    modport slave  (input  _cs, input  _write, input  rs);
endinterface

// File: rtl/fake6525.sv
// fake6525: clocked three-port TPI with per-bit direction registers and a
// 6525-style interrupt mode on the low port C bits (edge latch, mask, priority, open-drain _irq).
module fake6525 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned IRQ_LINES   = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             _reset,
    fake6525_if.slave        bus,
    inout  wire  [WIDTH-1:0] data,
    inout  wire  [WIDTH-1:0] port_a,
    inout  wire  [WIDTH-1:0] port_b,
    inout  wire  [WIDTH-1:0] port_c,
    output wire              _irq
);

    typedef enum logic [2:0] {
        RS_PRA  = 3'd0,
        RS_PRB  = 3'd1,
        RS_PRC  = 3'd2,
        RS_DDRA = 3'd3,
        RS_DDRB = 3'd4,
        RS_DDRC = 3'd5,
        RS_CR   = 3'd6,
        RS_AIR  = 3'd7
    } rs_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    // Port C bit positions that become interrupt lines in interrupt mode
    localparam logic [WIDTH-1:0] IRQ_BITS = ~(ALL_ONES << IRQ_LINES);

    rs_e              sel;
    logic             wr_en;
    logic             rd_drive;

    logic [WIDTH-1:0] pra_q, prb_q, prc_q, ddra_q, ddrb_q, ddrc_q, cr_q, lat_q;
    logic [WIDTH-1:0] pra_d, prb_d, prc_d, ddra_d, ddrb_d, ddrc_d, cr_d, lat_d;
    logic             irq_q, irq_d;

    logic [3*WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   prev_c_q;
    logic [WIDTH-1:0]   sync_a, sync_b, sync_c;

    logic             mc;
    logic [WIDTH-1:0] oe_c;
    logic [WIDTH-1:0] pin_c_rd;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] air;
    logic [WIDTH-1:0] rdata;

    assign sel      = rs_e'(bus.rs);
    assign wr_en    = !bus._cs && !bus._write;
    assign rd_drive = !bus._cs && bus._write && _reset;

    assign {sync_c, sync_b, sync_a} = sync_q[SYNC_STAGES-1];

    assign mc       = cr_q[0];
    // Interrupt lines are forced to input while in interrupt mode; DDRC then acts as the mask
    assign oe_c     = mc ? (ddrc_q & ~IRQ_BITS) : ddrc_q;
    assign pin_c_rd = (prc_q & oe_c) | (sync_c & ~oe_c);
    assign pending  = lat_q & ddrc_q;
    assign irq_d    = |pending;

    // Pin synchronisers for all ports, plus the previous synchronised port C sample (runs in both modes)
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_c_q <= '0;
        end else begin
            sync_q[0] <= {port_c, port_b, port_a};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_c_q <= sync_c;
        end
    end

    // Register file, interrupt latch and registered interrupt output
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            pra_q  <= '0;
            prb_q  <= '0;
            prc_q  <= '0;
            ddra_q <= '0;
            ddrb_q <= '0;
            ddrc_q <= '0;
            cr_q   <= '0;
            lat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            pra_q  <= pra_d;
            prb_q  <= prb_d;
            prc_q  <= prc_d;
            ddra_q <= ddra_d;
            ddrb_q <= ddrb_d;
            ddrc_q <= ddrc_d;
            cr_q   <= cr_d;
            lat_q  <= lat_d;
            irq_q  <= irq_d;
        end
    end

    // Host register writes; AIR is read-only
    always_comb begin
        pra_d  = pra_q;
        prb_d  = prb_q;
        prc_d  = prc_q;
        ddra_d = ddra_q;
        ddrb_d = ddrb_q;
        ddrc_d = ddrc_q;
        cr_d   = cr_q;
        if (wr_en) begin
            case (sel)
                RS_PRA:  pra_d  = data;
                RS_PRB:  prb_d  = data;
                RS_PRC:  prc_d  = data;
                RS_DDRA: ddra_d = data;
                RS_DDRB: ddrb_d = data;
                RS_DDRC: ddrc_d = data;
                RS_CR:   cr_d   = data;
                default: ;
            endcase
        end
    end

    // Interrupt latch: set on selected edge, write-one-to-clear via PRC, set wins; held clear outside interrupt mode
    always_comb begin
        w1c      = (wr_en && sel == RS_PRC) ? data : '0;
        edge_hit = cr_q[1] ? (sync_c & ~prev_c_q) : (~sync_c & prev_c_q);
        lat_d    = ((lat_q & ~w1c) | edge_hit) & IRQ_BITS;
        // Cleared when interrupt mode is off now or is being switched off on this edge
        if (!cr_q[0] || !cr_d[0]) begin
            lat_d = '0;
        end
    end

    // Priority encoder: one-hot of the highest pending line
    always_comb begin
        air = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pending[i]) begin
                air    = '0;
                air[i] = 1'b1;
            end
        end
    end

    // Combinational read-back mux
    always_comb begin
        rdata = '0;
        case (sel)
            RS_PRA:  rdata = (pra_q & ddra_q) | (sync_a & ~ddra_q);
            RS_PRB:  rdata = (prb_q & ddrb_q) | (sync_b & ~ddrb_q);
            RS_PRC:  rdata = mc ? ((pin_c_rd & ~IRQ_BITS) | lat_q) : pin_c_rd;
            RS_DDRA: rdata = ddra_q;
            RS_DDRB: rdata = ddrb_q;
            RS_DDRC: rdata = ddrc_q;
            RS_CR:   rdata = cr_q;
            RS_AIR:  rdata = air;
            default: rdata = '0;
        endcase
    end

    assign data = rd_drive ? rdata : 'z;
    assign _irq = irq_q ? 1'b0 : 1'bz;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign port_a[g] = ddra_q[g] ? pra_q[g] : 1'bz;
        assign port_b[g] = ddrb_q[g] ? prb_q[g] : 1'bz;
        assign port_c[g] = oe_c[g]   ? prc_q[g] : 1'bz;
    end

endmodule
